ahb_sram_responder: RTL and testbench
=====================================

Name: ahb_sram_responder

Overview:
- AHB-Lite responder that sits on a bus-matrix output port.
- Consumes the muxed slave-side signals: HSEL, address/control, HREADY (the muxed HREADY) and HWDATA.
- Returns HREADYOUT, HRESP and HRDATA.
- Drives a single-port synchronous SRAM with configurable read wait states, byte-lane writes and a read-after-write collision stall.

Parameters:
AW, 14, SRAM word-address width (memory = 2**AW x 32 bits)
WAIT_STATES, 0, extra read data-phase wait cycles (0..3)

Ports:
HCLK  input  1  AHB system clock
HRESETn  input  1  asynchronous active-low reset
HSEL  input  1  slave select from matrix output
HADDR  input  32  transfer address
HTRANS  input  2  transfer type
HWRITE  input  1  transfer direction
HSIZE  input  3  transfer size
HREADY  input  1  muxed HREADY (transfer done on bus)
HWDATA  input  32  write data (data phase)
HREADYOUT  output  1  slave ready
HRESP  output  1  0=OKAY, 1=ERROR
HRDATA  output  32  read data
SRAMCS  output  1  SRAM chip select
SRAMADDR  output  AW  SRAM word address
SRAMWEN  output  4  byte write enables (0 = read)
SRAMWDATA  output  32  SRAM write data
SRAMRDATA  input  32  SRAM read data, valid one cycle after read CS

Behaviour:
- Clock and reset: one clock, HCLK; reset HRESETn is asynchronous, active-low.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, SRAMCS=0, SRAMWEN=0, SRAMADDR=0, SRAMWDATA=0, state IDLE, wait counter=0.
- Accept: transfer accepted when HSEL & HREADY & HTRANS[1]. On accept, register address[AW+1:2], byte lanes, HWRITE.
- IDLE/BUSY, or HSEL=0 with HREADY: zero-wait OKAY, no SRAM access.
- Byte lanes:
  - HSIZE=0: one-hot on HADDR[1:0].
  - HSIZE=1: HADDR[1] ? 4'b1100 : 4'b0011.
  - HSIZE=2: 4'b1111.
- States: IDLE, WR, RD, RD_STALL, ERR1, ERR2.
- Read, no collision:
  - In the address phase, SRAMCS=1, SRAMADDR=HADDR[AW+1:2], SRAMWEN=0.
  - Next state RD. RD holds HREADYOUT=0 for WAIT_STATES cycles via a down-counter.
  - Final cycle: HREADYOUT=1, HRDATA=SRAMRDATA. HRDATA is 0 outside the final read cycle.
- Write:
  - State WR (data phase): SRAMCS=1, SRAMADDR=registered address, SRAMWEN=registered lanes, SRAMWDATA=HWDATA, HREADYOUT=1.
  - Writes never insert wait states.
- Collision: read accepted while in WR (SRAM port busy).
  - Read SRAM access deferred to the next cycle.
  - Next state RD_STALL: HREADYOUT=0 one cycle, SRAM read issued from registered address, then RD behaviour.
  - Total read latency = 2 + WAIT_STATES cycles.
- Back-to-back:
  - Pipelined transfers accepted on every cycle HREADYOUT=1.
  - Write after read: zero stall.
  - Write after write: zero stall.
- HRESP=0 in all non-error states.
- Reset mid-transfer: return to IDLE immediately, SRAMWEN forced 0 (no partial write), counter cleared.
- SRAMWEN is nonzero only in WR state.

Optional Feature:
Macro AHB_SRAM_RESP_ERR_EN.
- Defined: an accepted transfer with HSIZE>2, or misaligned (HSIZE=1 & HADDR[0], HSIZE=2 & HADDR[1:0]!=0), enters ERR1 → ERR2.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
  - No SRAM access; the pending address is discarded.
  - A transfer accepted during ERR2 is processed normally.
- Undefined: HRESP tied 0. HSIZE>2 treated as word. Misaligned accesses use the lane rules above, with address[1:0] ignored for word.

Test Plan:
- Reset with HRESETn=0 mid-RD → HREADYOUT=1, HRESP=0, SRAMCS=0, HRDATA=0 on the same edge; state IDLE after release.
- Halfword write: HADDR=0x0000_0006, HSIZE=1, HWDATA=0xABCD_0000, then word read of 0x4 (WAIT_STATES=0):
  - Write data phase: SRAMWEN=4'b1100, SRAMADDR=1.
  - Read: one RD_STALL cycle, then HRDATA=0xABCD_xxxx in the next cycle with HREADYOUT=1.
- WAIT_STATES=2, single read of 0x10 → HREADYOUT low exactly 2 data-phase cycles, SRAMADDR=4, HRDATA=SRAMRDATA on the 3rd cycle.
- Back-to-back writes to 0x0, 0x4, 0x8 (word, NONSEQ/SEQ) → HREADYOUT constantly 1, SRAMWEN=4'b1111 on three consecutive cycles with SRAMADDR 0, 1, 2.
- With AHB_SRAM_RESP_ERR_EN: word write to 0x0000_0002 → ERR1 (HREADYOUT=0, HRESP=1), ERR2 (HREADYOUT=1, HRESP=1), SRAMWEN=0 throughout. Without macro → write occurs with SRAMWEN=4'b1111, SRAMADDR=0, HRESP=0.
- HTRANS=IDLE with HSEL=1, then HSEL=0 with NONSEQ → HREADYOUT=1, HRESP=0, SRAMCS=0 both cycles.

Source files
------------

// File: rtl/ahb_sram_responder_if.sv
// ---------------------------------------------------------------------------
// ahb_sram_responder_if
// AHB-Lite slave-side signal bundle as seen on one bus-matrix output port.
//
// Signals:
//   HSEL, HADDR, HTRANS, HWRITE, HSIZE  address/control phase from the matrix
//   HREADY                              muxed HREADY (transfer completes on bus)
//   HWDATA                              write data (data phase)
//   HREADYOUT, HRESP, HRDATA            responder return path
//
// Modports:
//   master  drives the request side and observes the response (bench / matrix)
//   slave   the responder itself
// ---------------------------------------------------------------------------
interface ahb_sram_responder_if;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic        HREADY;
   logic [31:0] HWDATA;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
      input  HREADYOUT, HRESP, HRDATA
   );

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
      output HREADYOUT, HRESP, HRDATA
   );
endinterface

// File: rtl/ahb_sram_responder.sv
// ---------------------------------------------------------------------------
// ahb_sram_responder
// AHB-Lite responder that maps a bus-matrix output port onto a single-port
// synchronous SRAM (2**AW x 32). Reads may carry WAIT_STATES extra data-phase
// cycles; writes are always zero-wait and use byte-lane enables. A read that
// arrives while a write is occupying the SRAM port is stalled for one cycle.
//
// Parameters:
//   AW           SRAM word-address width
//   WAIT_STATES  extra read data-phase wait cycles (0..3)
//
// Ports:
//   HCLK, HRESETn   clock, asynchronous active-low reset
//   ahb             AHB-Lite slave modport (request in, HREADYOUT/HRESP/HRDATA out)
//   SRAMCS          SRAM chip select
//   SRAMADDR        SRAM word address
//   SRAMWEN         byte write enables (all zero = read)
//   SRAMWDATA       SRAM write data
//   SRAMRDATA       SRAM read data, valid the cycle after a read select
//
// Optional feature macro: AHB_SRAM_RESP_ERR_EN
//   When defined, oversize (HSIZE>2) or misaligned transfers receive a
//   two-cycle ERROR response with no SRAM access. When undefined, HRESP is
//   tied OKAY and such transfers are served using the ordinary lane rules.
// ---------------------------------------------------------------------------
module ahb_sram_responder #(
   parameter int AW          = 14,
   parameter int WAIT_STATES = 0
) (
   input  logic                HCLK,
   input  logic                HRESETn,
   ahb_sram_responder_if.slave ahb,
   output logic                SRAMCS,
   output logic [AW-1:0]       SRAMADDR,
   output logic [3:0]          SRAMWEN,
   output logic [31:0]         SRAMWDATA,
   input  logic [31:0]         SRAMRDATA
);

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD,
      RD_STALL,
      ERR1,
      ERR2
   } state_t;

   localparam logic [1:0] WS = 2'(WAIT_STATES);

   state_t        state;
   logic [AW-1:0] addr_q;
   logic [3:0]    lanes_q;
   logic [1:0]    wait_cnt;
   logic          ready_q;
   logic          resp_q;
   logic          rd_final_q;

   logic          accept;
   logic          bad;
   logic          rd_now;
   logic [3:0]    lanes;

   // Reset is folded into accept so nothing reaches the SRAM while the
   // block is held in reset, even if the bus is still presenting a transfer.
   assign accept = HRESETn & ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];

   // Byte lanes for the address-phase transfer; any size above halfword is
   // treated as a full word.
   always_comb begin
      lanes = 4'b1111;
      case (ahb.HSIZE)
         3'd0:    lanes = 4'b0001 << ahb.HADDR[1:0];
         3'd1:    lanes = ahb.HADDR[1] ? 4'b1100 : 4'b0011;
         default: lanes = 4'b1111;
      endcase
   end

`ifdef AHB_SRAM_RESP_ERR_EN
   // Oversize or misaligned transfers are refused with an ERROR response.
   assign bad = (ahb.HSIZE > 3'd2)
              | ((ahb.HSIZE == 3'd1) & ahb.HADDR[0])
              | ((ahb.HSIZE == 3'd2) & (ahb.HADDR[1:0] != 2'b00));
   assign ahb.HRESP = resp_q;
   logic unused_ok;
   assign unused_ok = &{1'b0, ahb.HADDR[31:AW+2], ahb.HTRANS[0]};
`else
   assign bad = 1'b0;
   assign ahb.HRESP = 1'b0;
   logic unused_ok;
   assign unused_ok = &{1'b0, ahb.HADDR[31:AW+2], ahb.HTRANS[0], resp_q};
`endif

   // A read can go straight to the SRAM in its address phase unless the port
   // is carrying a write data phase; that case is deferred via RD_STALL.
   assign rd_now = accept & ~ahb.HWRITE & ~bad & (state != WR);

   assign ahb.HREADYOUT = ready_q;
   assign ahb.HRDATA    = rd_final_q ? SRAMRDATA : 32'h0;

   // SRAM port steering. Writes use the registered address/lanes with the
   // live data-phase HWDATA. During read wait cycles the select is held so
   // the SRAM output stays refreshed until the final data-phase cycle.
   always_comb begin
      SRAMCS    = 1'b0;
      SRAMADDR  = '0;
      SRAMWEN   = 4'b0000;
      SRAMWDATA = 32'h0;
      case (state)
         WR: begin
            SRAMCS    = 1'b1;
            SRAMADDR  = addr_q;
            SRAMWEN   = lanes_q;
            SRAMWDATA = ahb.HWDATA;
         end
         RD_STALL: begin
            SRAMCS   = 1'b1;
            SRAMADDR = addr_q;
         end
         default: begin
            if (state == RD && wait_cnt != 2'd0) begin
               SRAMCS   = 1'b1;
               SRAMADDR = addr_q;
            end else if (rd_now) begin
               SRAMCS   = 1'b1;
               SRAMADDR = ahb.HADDR[AW+1:2];
            end
         end
      endcase
   end

   // Transfer FSM. HREADYOUT, HRESP and the read-data gate are computed one
   // cycle ahead so they come straight from flops. New transfers are only
   // considered in states where HREADYOUT is high.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state      <= IDLE;
         addr_q     <= '0;
         lanes_q    <= 4'b0000;
         wait_cnt   <= 2'd0;
         ready_q    <= 1'b1;
         resp_q     <= 1'b0;
         rd_final_q <= 1'b0;
      end else begin
         rd_final_q <= 1'b0;
         resp_q     <= 1'b0;
         case (state)
            RD_STALL: begin
               state      <= RD;
               wait_cnt   <= WS;
               ready_q    <= (WS == 2'd0);
               rd_final_q <= (WS == 2'd0);
            end
            ERR1: begin
               state   <= ERR2;
               ready_q <= 1'b1;
               resp_q  <= 1'b1;
            end
            default: begin
               if (state == RD && wait_cnt != 2'd0) begin
                  wait_cnt   <= wait_cnt - 2'd1;
                  ready_q    <= (wait_cnt == 2'd1);
                  rd_final_q <= (wait_cnt == 2'd1);
               end else if (accept) begin
                  if (bad) begin
                     state   <= ERR1;
                     ready_q <= 1'b0;
                     resp_q  <= 1'b1;
                  end else if (ahb.HWRITE) begin
                     state   <= WR;
                     addr_q  <= ahb.HADDR[AW+1:2];
                     lanes_q <= lanes;
                     ready_q <= 1'b1;
                  end else if (state == WR) begin
                     state   <= RD_STALL;
                     addr_q  <= ahb.HADDR[AW+1:2];
                     ready_q <= 1'b0;
                  end else begin
                     state      <= RD;
                     addr_q     <= ahb.HADDR[AW+1:2];
                     wait_cnt   <= WS;
                     ready_q    <= (WS == 2'd0);
                     rd_final_q <= (WS == 2'd0);
                  end
               end else begin
                  state   <= IDLE;
                  ready_q <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_ahb_sram_responder
// Directed bench for ahb_sram_responder. Two instances are used: dut0 with
// WAIT_STATES=0 and dut2 with WAIT_STATES=2, each with its own behavioural
// SRAM. HREADY of each bus is looped back from that instance's HREADYOUT, as
// on a matrix port with a single active slave. Inputs change 1 time unit
// after the rising edge; outputs are examined on the falling edge.
// Optional feature macro: AHB_SRAM_RESP_ERR_EN (selects the error test flavour)
// ---------------------------------------------------------------------------
module tb_ahb_sram_responder;

   localparam logic [1:0] HT_IDLE   = 2'b00;
   localparam logic [1:0] HT_NONSEQ = 2'b10;
   localparam logic [1:0] HT_SEQ    = 2'b11;

   logic HCLK = 1'b0;
   logic HRESETn;
   int   checks = 0;
   int   errors = 0;

   always #5 HCLK = ~HCLK;

   ahb_sram_responder_if bus0();
   ahb_sram_responder_if bus2();

   assign bus0.HREADY = bus0.HREADYOUT;
   assign bus2.HREADY = bus2.HREADYOUT;

   logic        cs0, cs2;
   logic [13:0] addr0, addr2;
   logic [3:0]  wen0, wen2;
   logic [31:0] wdata0, wdata2, rdata0, rdata2;

   logic [31:0] mem0 [0:16383];
   logic [31:0] mem2 [0:16383];
   logic        pre_we0, pre_we2;
   logic [13:0] pre_addr;
   logic [31:0] pre_data;

   ahb_sram_responder #(.AW(14), .WAIT_STATES(0)) dut0 (
      .HCLK(HCLK), .HRESETn(HRESETn), .ahb(bus0),
      .SRAMCS(cs0), .SRAMADDR(addr0), .SRAMWEN(wen0),
      .SRAMWDATA(wdata0), .SRAMRDATA(rdata0)
   );

   ahb_sram_responder #(.AW(14), .WAIT_STATES(2)) dut2 (
      .HCLK(HCLK), .HRESETn(HRESETn), .ahb(bus2),
      .SRAMCS(cs2), .SRAMADDR(addr2), .SRAMWEN(wen2),
      .SRAMWDATA(wdata2), .SRAMRDATA(rdata2)
   );

   // Behavioural single-port SRAMs with a preload port for initial contents.
   always @(posedge HCLK) begin
      if (pre_we0) mem0[pre_addr] <= pre_data;
      else if (cs0) begin
         if (wen0 == 4'b0000) rdata0 <= mem0[addr0];
         else for (int b = 0; b < 4; b++)
            if (wen0[b]) mem0[addr0][8*b +: 8] <= wdata0[8*b +: 8];
      end
   end

   always @(posedge HCLK) begin
      if (pre_we2) mem2[pre_addr] <= pre_data;
      else if (cs2) begin
         if (wen2 == 4'b0000) rdata2 <= mem2[addr2];
         else for (int b = 0; b < 4; b++)
            if (wen2[b]) mem2[addr2][8*b +: 8] <= wdata2[8*b +: 8];
      end
   end

   task automatic next_cycle;
      @(posedge HCLK);
      #1;
   endtask

   task automatic drive0(input logic sel, input logic [1:0] trans, input logic wr,
                         input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
      bus0.HSEL   = sel;
      bus0.HTRANS = trans;
      bus0.HWRITE = wr;
      bus0.HSIZE  = size;
      bus0.HADDR  = addr;
      bus0.HWDATA = wdata;
   endtask

   task automatic drive2(input logic sel, input logic [1:0] trans, input logic wr,
                         input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
      bus2.HSEL   = sel;
      bus2.HTRANS = trans;
      bus2.HWRITE = wr;
      bus2.HSIZE  = size;
      bus2.HADDR  = addr;
      bus2.HWDATA = wdata;
   endtask

   // Reset state of both instances, plus SRAM preload while reset is held.
   task automatic test_reset;
      HRESETn  = 1'b1;
      pre_we0  = 1'b0;
      pre_we2  = 1'b0;
      pre_addr = 14'd0;
      pre_data = 32'h0;
      drive0(1'b0, HT_IDLE, 1'b0, 3'd2, 32'h0, 32'h0);
      drive2(1'b0, HT_IDLE, 1'b0, 3'd2, 32'h0, 32'h0);
      #2 HRESETn = 1'b0;
      @(negedge HCLK);
      checks++;
      if ({bus0.HREADYOUT, bus0.HRESP, cs0, wen0, addr0, wdata0, bus0.HRDATA} !==
          {1'b1, 1'b0, 1'b0, 4'b0000, 14'd0, 32'h0, 32'h0}) begin
         errors++;
         $display("[TB] FAIL reset_dut0 got rdy=%b resp=%b cs=%b wen=%b addr=%h wd=%h rd=%h exp 1 0 0 0000 0 0 0",
                  bus0.HREADYOUT, bus0.HRESP, cs0, wen0, addr0, wdata0, bus0.HRDATA);
      end
      checks++;
      if ({bus2.HREADYOUT, bus2.HRESP, cs2, wen2, addr2, bus2.HRDATA} !==
          {1'b1, 1'b0, 1'b0, 4'b0000, 14'd0, 32'h0}) begin
         errors++;
         $display("[TB] FAIL reset_dut2 got rdy=%b resp=%b cs=%b wen=%b addr=%h rd=%h exp 1 0 0 0000 0 0",
                  bus2.HREADYOUT, bus2.HRESP, cs2, wen2, addr2, bus2.HRDATA);
      end
      next_cycle();
      pre_addr = 14'd1;
      pre_data = 32'h1111_2222;
      pre_we0  = 1'b1;
      next_cycle();
      pre_we0  = 1'b0;
      pre_addr = 14'd4;
      pre_data = 32'hCAFE_F00D;
      pre_we2  = 1'b1;
      next_cycle();
      pre_we2  = 1'b0;
      HRESETn  = 1'b1;
   endtask

   // Halfword write to 0x6 followed immediately by a word read of 0x4.
   task automatic test_halfword_collision;
      next_cycle();
      drive0(1'b1, HT_NONSEQ, 1'b1, 3'd1, 32'h0000_0006, 32'h0);
      @(negedge HCLK);
      checks++;
      if ({bus0.HREADYOUT, cs0} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL hw_addr_phase got rdy,cs=%b exp 10", {bus0.HREADYOUT, cs0});
      end
      next_cycle();
      drive0(1'b1, HT_NONSEQ, 1'b0, 3'd2, 32'h0000_0004, 32'hABCD_0000);
      @(negedge HCLK);
      checks++;
      if ({bus0.HREADYOUT, cs0, wen0, addr0, wdata0} !==
          {1'b1, 1'b1, 4'b1100, 14'd1, 32'hABCD_0000}) begin
         errors++;
         $display("[TB] FAIL hw_write_data got rdy=%b cs=%b wen=%b addr=%h wd=%h exp 1 1 1100 0001 abcd0000",
                  bus0.HREADYOUT, cs0, wen0, addr0, wdata0);
      end
      next_cycle();
      drive0(1'b0, HT_IDLE, 1'b0, 3'd2, 32'h0, 32'h0);
      @(negedge HCLK);
      checks++;
      if ({bus0.HREADYOUT, cs0, wen0, addr0, bus0.HRDATA} !==
          {1'b0, 1'b1, 4'b0000, 14'd1, 32'h0}) begin
         errors++;
         $display("[TB] FAIL rd_stall got rdy=%b cs=%b wen=%b addr=%h rd=%h exp 0 1 0000 0001 0",
                  bus0.HREADYOUT, cs0, wen0, addr0, bus0.HRDATA);
      end
      next_cycle();
      @(negedge HCLK);
      checks++;
      if ({bus0.HREADYOUT, bus0.HRDATA} !== {1'b1, 32'hABCD_2222}) begin
         errors++;
         $display("[TB] FAIL stall_read_data got rdy=%b rd=%h exp 1 abcd2222", bus0.HREADYOUT, bus0.HRDATA);
      end
   endtask

   // WAIT_STATES=2 read of 0x10 on dut2.
   task automatic test_wait_states;
      next_cycle();
      drive2(1'b1, HT_NONSEQ, 1'b0, 3'd2, 32'h0000_0010, 32'h0);
      @(negedge HCLK);
      checks++;
      if ({bus2.HREADYOUT, cs2, addr2, wen2} !== {1'b1, 1'b1, 14'd4, 4'b0000}) begin
         errors++;
         $display("[TB] FAIL ws_addr_phase got rdy=%b cs=%b addr=%h wen=%b exp 1 1 0004 0000",
                  bus2.HREADYOUT, cs2, addr2, wen2);
      end
      next_cycle();
      drive2(1'b0, HT_IDLE, 1'b0, 3'd2, 32'h0, 32'h0);
      @(negedge HCLK);
      checks++;
      if ({bus2.HREADYOUT, bus2.HRDATA} !== {1'b0, 32'h0}) begin
         errors++;
         $display("[TB] FAIL ws_wait1 got rdy=%b rd=%h exp 0 0", bus2.HREADYOUT, bus2.HRDATA);
      end
      next_cycle();
      @(negedge HCLK);
      checks++;
      if (bus2.HREADYOUT !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ws_wait2 got rdy=%b exp 0", bus2.HREADYOUT);
      end
      next_cycle();
      @(negedge HCLK);
      checks++;
      if ({bus2.HREADYOUT, bus2.HRDATA} !== {1'b1, 32'hCAFE_F00D}) begin
         errors++;
         $display("[TB] FAIL ws_final got rdy=%b rd=%h exp 1 cafef00d", bus2.HREADYOUT, bus2.HRDATA);
      end
      next_cycle();
      @(negedge HCLK);
      checks++;
      if ({bus2.HREADYOUT, bus2.HRDATA, cs2} !== {1'b1, 32'h0, 1'b0}) begin
         errors++;
         $display("[TB] FAIL ws_after got rdy=%b rd=%h cs=%b exp 1 0 0", bus2.HREADYOUT, bus2.HRDATA, cs2);
      end
   endtask

   // Three pipelined word writes, then a byte write to 0x3.
   task automatic test_back_to_back;
      next_cycle();
      drive0(1'b1, HT_NONSEQ, 1'b1, 3'd2, 32'h0, 32'h0);
      @(negedge HCLK);
      checks++;
      if (bus0.HREADYOUT !== 1'b1) begin
         errors++;
         $display("[TB] FAIL b2b_first_addr got rdy=%b exp 1", bus0.HREADYOUT);
      end
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         if (i < 2) drive0(1'b1, HT_SEQ, 1'b1, 3'd2, 32'(4 * (i + 1)), 32'h0000_0A00 + 32'(i) * 32'h100);
         else       drive0(1'b0, HT_IDLE, 1'b0, 3'd2, 32'h0, 32'h0000_0C00);
         @(negedge HCLK);
         checks++;
         if ({bus0.HREADYOUT, cs0, wen0, addr0, wdata0} !==
             {1'b1, 1'b1, 4'b1111, 14'(i), 32'h0000_0A00 + 32'(i) * 32'h100}) begin
            errors++;
            $display("[TB] FAIL b2b_write%0d got rdy=%b cs=%b wen=%b addr=%h wd=%h exp 1 1 1111 %h %h",
                     i, bus0.HREADYOUT, cs0, wen0, addr0, wdata0, 14'(i), 32'h0000_0A00 + 32'(i) * 32'h100);
         end
      end
      next_cycle();
      drive0(1'b1, HT_NONSEQ, 1'b1, 3'd0, 32'h0000_0003, 32'h0);
      @(negedge HCLK);
      checks++;
      if ({cs0, wen0} !== 5'b00000) begin
         errors++;
         $display("[TB] FAIL b2b_idle_gap got cs=%b wen=%b exp 0 0000", cs0, wen0);
      end
      next_cycle();
      drive0(1'b0, HT_IDLE, 1'b0, 3'd2, 32'h0, 32'h7700_0000);
      @(negedge HCLK);
      checks++;
      if ({wen0, addr0} !== {4'b1000, 14'd0}) begin
         errors++;
         $display("[TB] FAIL byte_lane got wen=%b addr=%h exp 1000 0000", wen0, addr0);
      end
   endtask

   // Word read of 0x0 immediately followed by a write to 0xC.
   task automatic test_read_then_write;
      next_cycle();
      drive0(1'b1, HT_NONSEQ, 1'b0, 3'd2, 32'h0, 32'h0);
      @(negedge HCLK);
      checks++;
      if ({cs0, wen0, addr0} !== {1'b1, 4'b0000, 14'd0}) begin
         errors++;
         $display("[TB] FAIL rw_read_addr got cs=%b wen=%b addr=%h exp 1 0000 0000", cs0, wen0, addr0);
      end
      next_cycle();
      drive0(1'b1, HT_NONSEQ, 1'b1, 3'd2, 32'h0000_000C, 32'h0);
      @(negedge HCLK);
      checks++;
      if ({bus0.HREADYOUT, bus0.HRDATA} !== {1'b1, 32'h7700_0A00}) begin
         errors++;
         $display("[TB] FAIL rw_read_data got rdy=%b rd=%h exp 1 77000a00", bus0.HREADYOUT, bus0.HRDATA);
      end
      next_cycle();
      drive0(1'b0, HT_IDLE, 1'b0, 3'd2, 32'h0, 32'h5555_AAAA);
      @(negedge HCLK);
      checks++;
      if ({bus0.HREADYOUT, cs0, wen0, addr0, wdata0} !==
          {1'b1, 1'b1, 4'b1111, 14'd3, 32'h5555_AAAA}) begin
         errors++;
         $display("[TB] FAIL rw_write got rdy=%b cs=%b wen=%b addr=%h wd=%h exp 1 1 1111 0003 5555aaaa",
                  bus0.HREADYOUT, cs0, wen0, addr0, wdata0);
      end
   endtask

   // Misaligned word write to 0x2.
   task automatic test_error;
      next_cycle();
      drive0(1'b1, HT_NONSEQ, 1'b1, 3'd2, 32'h0000_0002, 32'h0);
      next_cycle();
      drive0(1'b0, HT_IDLE, 1'b0, 3'd2, 32'h0, 32'h1234_5678);
      @(negedge HCLK);
`ifdef AHB_SRAM_RESP_ERR_EN
      checks++;
      if ({bus0.HREADYOUT, bus0.HRESP, cs0, wen0} !== 7'b0100000) begin
         errors++;
         $display("[TB] FAIL err1 got rdy=%b resp=%b cs=%b wen=%b exp 0 1 0 0000",
                  bus0.HREADYOUT, bus0.HRESP, cs0, wen0);
      end
      next_cycle();
      @(negedge HCLK);
      checks++;
      if ({bus0.HREADYOUT, bus0.HRESP, cs0, wen0} !== 7'b1100000) begin
         errors++;
         $display("[TB] FAIL err2 got rdy=%b resp=%b cs=%b wen=%b exp 1 1 0 0000",
                  bus0.HREADYOUT, bus0.HRESP, cs0, wen0);
      end
      next_cycle();
      @(negedge HCLK);
      checks++;
      if ({bus0.HREADYOUT, bus0.HRESP} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL err_done got rdy,resp=%b exp 10", {bus0.HREADYOUT, bus0.HRESP});
      end
`else
      checks++;
      if ({bus0.HREADYOUT, bus0.HRESP, cs0, wen0, addr0, wdata0} !==
          {1'b1, 1'b0, 1'b1, 4'b1111, 14'd0, 32'h1234_5678}) begin
         errors++;
         $display("[TB] FAIL misaligned_write got rdy=%b resp=%b cs=%b wen=%b addr=%h wd=%h exp 1 0 1 1111 0000 12345678",
                  bus0.HREADYOUT, bus0.HRESP, cs0, wen0, addr0, wdata0);
      end
`endif
   endtask

   // IDLE transfer with HSEL=1, then an unselected NONSEQ.
   task automatic test_idle_transfers;
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         case (i)
            0:       drive0(1'b1, HT_IDLE,   1'b0, 3'd2, 32'h0000_0010, 32'h0);
            1:       drive0(1'b0, HT_NONSEQ, 1'b0, 3'd2, 32'h0000_0010, 32'h0);
            default: drive0(1'b0, HT_IDLE,   1'b0, 3'd2, 32'h0, 32'h0);
         endcase
         @(negedge HCLK);
         checks++;
         if ({bus0.HREADYOUT, bus0.HRESP, cs0} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL idle_cycle%0d got rdy=%b resp=%b cs=%b exp 1 0 0",
                     i, bus0.HREADYOUT, bus0.HRESP, cs0);
         end
      end
   endtask

   // Asynchronous reset asserted in the middle of a dut2 read wait.
   task automatic test_reset_mid_read;
      next_cycle();
      drive2(1'b1, HT_NONSEQ, 1'b0, 3'd2, 32'h0000_0010, 32'h0);
      next_cycle();
      drive2(1'b0, HT_IDLE, 1'b0, 3'd2, 32'h0, 32'h0);
      @(negedge HCLK);
      checks++;
      if ({bus2.HREADYOUT, cs2} !== 2'b01) begin
         errors++;
         $display("[TB] FAIL mid_rd_before got rdy,cs=%b exp 01", {bus2.HREADYOUT, cs2});
      end
      #1 HRESETn = 1'b0;
      #1;
      checks++;
      if ({bus2.HREADYOUT, bus2.HRESP, cs2, wen2, bus2.HRDATA} !== {1'b1, 1'b0, 1'b0, 4'b0000, 32'h0}) begin
         errors++;
         $display("[TB] FAIL mid_rd_reset got rdy=%b resp=%b cs=%b wen=%b rd=%h exp 1 0 0 0000 0",
                  bus2.HREADYOUT, bus2.HRESP, cs2, wen2, bus2.HRDATA);
      end
      #1 HRESETn = 1'b1;
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         @(negedge HCLK);
         checks++;
         if ({bus2.HREADYOUT, bus2.HRESP, cs2, bus2.HRDATA} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("[TB] FAIL post_reset%0d got rdy=%b resp=%b cs=%b rd=%h exp 1 0 0 0",
                     i, bus2.HREADYOUT, bus2.HRESP, cs2, bus2.HRDATA);
         end
      end
   endtask

   initial begin
      test_reset();
      test_halfword_collision();
      test_wait_states();
      test_back_to_back();
      test_read_then_write();
      test_error();
      test_idle_transfers();
      test_reset_mid_read();
      next_cycle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
